ber_window_accumulator: RTL and testbench

- Downstream stage of the 8-bit error comparator; consumes its per-byte error vector (1 = mismatched bit).
- Accumulates errored-bit and total-bit counts over a programmable measurement window of N bytes, then latches the results and pulses done.
- Also flags loss of pattern lock when the error density stays high for a sustained run of bytes.
- Results feed the BER readout/host interface.

---
 rtl/ber_window_accumulator.sv | 158 +++++++++++++++
 tb/tb_ber_window_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_window_accumulator.sv
// BER window accumulator.
// Counts the errored bits and the total bits over a window of N bytes taken
// from the 8-bit error comparator. At the end of the window it latches the
// results and pulses done. It also sets a sticky flag when error density
// stays high for a sustained run of bytes (loss of pattern lock).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; results of the last window are held
// S_RUN  | window open; valid beats are accumulated into the live counters
// S_DONE | one-cycle done pulse; results were loaded on the entry edge
module ber_window_accumulator #(
  parameter int CNT_W    = 32,
  parameter int LOSS_THR = 4,
  parameter int LOSS_RUN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window_bytes,
  input  logic             err_valid,
  input  logic [7:0]       err_vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             err_sat,
  output logic             lock_lost
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                RUN_W   = 16;
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(LOSS_RUN);
  localparam logic [3:0]        THR     = 4'(LOSS_THR);

  state_t             state;
  logic [CNT_W-1:0]   win;
  logic [CNT_W-1:0]   live_err;
  logic [CNT_W-1:0]   live_bytes;
  logic [CNT_W-1:0]   live_bits;
  logic               live_sat;
  logic [RUN_W-1:0]   bad_run;

  logic [3:0]         pc;
  logic [CNT_W:0]     err_sum;
  logic               sat_now;
  logic [CNT_W-1:0]   err_next;
  logic [CNT_W-1:0]   bytes_next;
  logic [CNT_W-1:0]   bits_next;
  logic [RUN_W-1:0]   bad_next;

  // Popcount of the error vector for this beat.
  always_comb begin
    pc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pc = pc + {3'b000, err_vec[i]};
    end
  end

  // Next values of the live counters if the current beat is accepted.
  always_comb begin
    err_sum    = {1'b0, live_err} + (CNT_W + 1)'(pc);
    sat_now    = err_sum[CNT_W];
    err_next   = sat_now ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    bytes_next = live_bytes + CNT_W'(1);
    bits_next  = live_bits + CNT_W'(8);
    if (pc >= THR) begin
      bad_next = (bad_run == RUN_MAX) ? bad_run : bad_run + RUN_W'(1);
    end else begin
      bad_next = '0;
    end
  end

  // Window sequencing, accumulation, loss-of-lock tracking and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      win        <= '0;
      live_err   <= '0;
      live_bytes <= '0;
      live_bits  <= '0;
      live_sat   <= 1'b0;
      bad_run    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
      err_sat    <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !abort) begin
            win        <= window_bytes;
            live_err   <= '0;
            live_bytes <= '0;
            live_bits  <= '0;
            live_sat   <= 1'b0;
            bad_run    <= '0;
            lock_lost  <= 1'b0;
            if (window_bytes == '0) begin
              // Empty window: results are the freshly cleared counters.
              state     <= S_DONE;
              done      <= 1'b1;
              err_count <= '0;
              bit_count <= '0;
              err_sat   <= 1'b0;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            // Beat in the abort cycle is dropped; previous results are kept.
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (err_valid) begin
            live_err   <= err_next;
            live_bytes <= bytes_next;
            live_bits  <= bits_next;
            live_sat   <= live_sat | sat_now;
            bad_run    <= bad_next;
            if (bad_next == RUN_MAX) begin
              lock_lost <= 1'b1;
            end
            if (bytes_next == win) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              err_count <= err_next;
              bit_count <= bits_next;
              err_sat   <= live_sat | sat_now;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_window_accumulator.sv
// Directed bench for ber_window_accumulator: a table of windows with
// hand-computed results plus hand-written sequences for abort, loss of lock,
// empty window, start+abort, reset mid-window and counter saturation.
`timescale 1ns/1ps
module tb_ber_window_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] window_bytes = '0;
  logic        err_valid = 1'b0;
  logic [7:0]  err_vec = '0;
  logic        busy, done, err_sat, lock_lost;
  logic [31:0] err_count, bit_count;

  logic        s_start = 1'b0;
  logic        s_abort = 1'b0;
  logic [3:0]  s_wb = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_vec = '0;
  logic        s_busy, s_done, s_sat, s_lock;
  logic [3:0]  s_err, s_bits;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ber_window_accumulator #(.CNT_W(32), .LOSS_THR(4), .LOSS_RUN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .window_bytes(window_bytes), .err_valid(err_valid), .err_vec(err_vec),
    .busy(busy), .done(done), .err_count(err_count), .bit_count(bit_count),
    .err_sat(err_sat), .lock_lost(lock_lost)
  );

  ber_window_accumulator #(.CNT_W(4), .LOSS_THR(4), .LOSS_RUN(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .window_bytes(s_wb), .err_valid(s_valid), .err_vec(s_vec),
    .busy(s_busy), .done(s_done), .err_count(s_err), .bit_count(s_bits),
    .err_sat(s_sat), .lock_lost(s_lock)
  );

  typedef struct {
    logic [31:0]     wb;
    int              n;
    logic [3:0][7:0] pat;
    int              gap;
    logic [31:0]     e_err;
    logic [31:0]     e_bits;
    logic            e_sat;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Start a window, feed n beats (pattern repeats every 4) with gap idle
  // cycles before each beat, then check the done cycle and the cycle after.
  task automatic run_window(input string nm, input vec_t v);
    int bad_cycles;
    bad_cycles = 0;
    window_bytes = v.wb;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (v.wb != 0) begin
      check({nm, "_busy_start"}, 64'(busy), 64'(1));
      for (int i = 0; i < v.n; i++) begin
        for (int g = 0; g < v.gap; g++) begin
          err_valid = 1'b0;
          tick();
          if (done || !busy) bad_cycles++;
        end
        err_valid = 1'b1;
        err_vec = v.pat[i % 4];
        tick();
        err_valid = 1'b0;
        if (i < v.n - 1 && (done || !busy)) bad_cycles++;
      end
      check({nm, "_run_cycles"}, 64'(bad_cycles), 64'(0));
    end
    check({nm, "_done"}, 64'(done), 64'(1));
    check({nm, "_err"}, 64'(err_count), 64'(v.e_err));
    check({nm, "_bits"}, 64'(bit_count), 64'(v.e_bits));
    check({nm, "_sat"}, 64'(err_sat), 64'(v.e_sat));
    check({nm, "_busy_done"}, 64'(busy), 64'(0));
    tick();
    check({nm, "_done_clear"}, 64'(done), 64'(0));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{wb: 32'd4, n: 4, pat: {8'h00, 8'h00, 8'h00, 8'h00}, gap: 0,
                e_err: 32'd0, e_bits: 32'd32, e_sat: 1'b0};
    // pat is packed [3:0], so element 0 is the rightmost byte.
    vecs[1] = '{wb: 32'd3, n: 3, pat: {8'h00, 8'h81, 8'hFF, 8'h01}, gap: 2,
                e_err: 32'd11, e_bits: 32'd24, e_sat: 1'b0};
    vecs[2] = '{wb: 32'd2, n: 2, pat: {8'h00, 8'h00, 8'hC0, 8'h03}, gap: 1,
                e_err: 32'd4, e_bits: 32'd16, e_sat: 1'b0};
    vecs[3] = '{wb: 32'd5, n: 5, pat: {8'h55, 8'hAA, 8'h0F, 8'hF0}, gap: 0,
                e_err: 32'd20, e_bits: 32'd40, e_sat: 1'b0};

    #12;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err_count), 64'(0));
    check("reset_bits", 64'(bit_count), 64'(0));
    check("reset_lock", 64'(lock_lost), 64'(0));
    rst_n = 1'b1;
    tick();

    run_window("clean", vecs[0]);
    check("clean_lock", 64'(lock_lost), 64'(0));

    // Abort mid-window: previous results must survive, no done.
    begin
      int seen_done;
      seen_done = 0;
      window_bytes = 32'd10;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        err_valid = 1'b1;
        err_vec = 8'hFF;
        tick();
        if (done) seen_done++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      err_valid = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      for (int i = 0; i < 3; i++) begin
        if (done) seen_done++;
        tick();
      end
      check("abort_no_done", 64'(seen_done), 64'(0));
      check("abort_err_kept", 64'(err_count), 64'(0));
      check("abort_bits_kept", 64'(bit_count), 64'(32));
    end

    for (int k = 1; k < 4; k++) begin
      run_window($sformatf("vec%0d", k), vecs[k]);
    end

    // Loss of lock: 15 bad, 1 good, 16 bad, then 8 clean to close a 40-byte window.
    window_bytes = 32'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      err_valid = 1'b1;
      err_vec = (i == 16) ? 8'h07 : (i <= 32) ? 8'h0F : 8'h00;
      tick();
      if (i == 16) check("lock_beat16", 64'(lock_lost), 64'(0));
      if (i == 31) check("lock_beat31", 64'(lock_lost), 64'(0));
      if (i == 32) check("lock_beat32", 64'(lock_lost), 64'(1));
    end
    err_valid = 1'b0;
    check("lock_done", 64'(done), 64'(1));
    check("lock_err", 64'(err_count), 64'(127));
    check("lock_bits", 64'(bit_count), 64'(320));
    tick();
    check("lock_sticky_idle", 64'(lock_lost), 64'(1));

    // start together with abort in IDLE: ignored, nothing cleared.
    window_bytes = 32'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("startabort_busy", 64'(busy), 64'(0));
    check("startabort_done", 64'(done), 64'(0));
    check("startabort_lock", 64'(lock_lost), 64'(1));
    tick();
    check("startabort_done2", 64'(done), 64'(0));

    // Empty window clears lock and completes straight away with zero counts.
    v = '{wb: 32'd0, n: 0, pat: '0, gap: 0, e_err: 32'd0, e_bits: 32'd0, e_sat: 1'b0};
    run_window("empty", v);
    check("empty_lock_cleared", 64'(lock_lost), 64'(0));

    // Reset mid-window after a window with nonzero results.
    run_window("pre_reset", vecs[3]);
    window_bytes = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      err_valid = 1'b1;
      err_vec = 8'hFF;
      tick();
    end
    err_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_count), 64'(0));
    check("rst_bits", 64'(bit_count), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    v = '{wb: 32'd2, n: 2, pat: {8'h00, 8'h00, 8'h01, 8'h01}, gap: 0,
          e_err: 32'd2, e_bits: 32'd16, e_sat: 1'b0};
    run_window("post_reset", v);

    // Saturation on the 4-bit instance: 24 errors clamp to 15, bits wrap to 8.
    s_wb = 4'd3;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_vec = 8'hFF;
      tick();
    end
    s_valid = 1'b0;
    check("sat_done", 64'(s_done), 64'(1));
    check("sat_err", 64'(s_err), 64'(15));
    check("sat_flag", 64'(s_sat), 64'(1));
    check("sat_bits", 64'(s_bits), 64'(8));
    tick();
    s_wb = 4'd1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1;
    s_vec = 8'h01;
    tick();
    s_valid = 1'b0;
    check("sat2_done", 64'(s_done), 64'(1));
    check("sat2_err", 64'(s_err), 64'(1));
    check("sat2_flag", 64'(s_sat), 64'(0));
    check("sat2_bits", 64'(s_bits), 64'(8));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
